lhr_spec_queue: RTL and testbench
=================================

Name: lhr_spec_queue

Overview:
- Ordered speculative local-history queue: a small CAM that replaces the per-index speculative history RAM plus flushed-bit array in the local-history predictor.
- Writer side: D-stage branches allocate entries. Reader side: F-stage lookups return the youngest speculative local history register (LHR) for a BHT index. Repair side: E-stage mispredictions squash younger entries and correct the mispredicting entry. Commit side: W-stage pops the oldest entry.

Parameters:
- m, 6, BHT index width (2^m local histories)
- k, 10, LHR width
- ENTRIES, 8, queue depth; power of two, >=2
- TAGW, $clog2(ENTRIES), entry tag width

Ports:
- clk  in  1  clock
- reset  in  1  reset
- StallF  in  1  hold F lookup result
- IndexNextF  in  m  BHT index for the next fetch PC
- LookupHitF  out  1  registered: a valid entry matched IndexNextF
- LookupLHRF  out  k  registered: LHR of the youngest matching entry
- AllocD  in  1  allocate; qualified externally with ~StallE & ~FlushE
- AllocIndexD  in  m  index of the allocating branch
- AllocLHRD  in  k  speculative LHR after the D-stage shift
- AllocOkD  out  1  comb: allocation accepted (AllocD & ~full & ~RepairE)
- AllocTagD  out  TAGW  comb: tag of the slot being allocated (tail)
- RepairE  in  1  misprediction of a queued branch in E
- RepairTagE  in  TAGW  tag of the mispredicting branch
- RepairLHRE  in  k  corrected LHR (resolved direction shifted in)
- CommitW  in  1  oldest queued branch retires (asserted only for AllocOk branches)
- FullD  out  1  count == ENTRIES
- EmptyD  out  1  count == 0

Behaviour:
- State:
  - Per-entry Valid, Index[m], LHR[k].
  - Head pointer and tail pointer, each TAGW wide.
  - Count, TAGW+1 wide.
- Reset: all Valid=0, head=tail=0, count=0. LookupHitF=0, LookupLHRF=0, FullD=0, EmptyD=1.
- Reset mid-operation discards all entries with no commit side effects.
- Allocate (AllocOkD): write slot tail, set Valid, tail=tail+1 mod ENTRIES, count+1.
- Full: AllocD while full is dropped and AllocOkD=0. The predictor treats the branch as unqueued and never commits it.
- Commit (CommitW): clear Valid[head], head=head+1, count-1.
  - CommitW while empty is ignored.
  - Check: head slot must be valid.
- Repair (RepairE):
  - Write LHR[RepairTagE]=RepairLHRE.
  - Clear Valid on every slot strictly younger than RepairTagE, i.e. from RepairTagE+1 up to tail-1, with wrap.
  - tail=RepairTagE+1; count recomputed as (RepairTagE - head + 1) mod ENTRIES, with 0 meaning ENTRIES when the tag equals the full span.
- Simultaneous events:
  - RepairE and AllocD: repair wins and the allocation is dropped, because the D branch is younger and is being flushed.
  - RepairE and CommitW: both apply. The repaired tag is never the committing head unless it is the only entry, in which case the commit pops it after correction.
  - AllocD and CommitW: count is unchanged; pointers both advance. Allocation when full with a same-cycle commit is still dropped, because full is sampled before the edge.
- Lookup:
  - Compare IndexNextF against all valid entries and select the youngest match, measured as age relative to head.
  - On a clock edge with ~StallF, register hit and LHR.
  - With StallF, hold the outputs.
  - A same-cycle repair is reflected in the next lookup, not the current one.
  - Miss: LookupLHRF=0. The predictor then uses the committed BHT.
- Pointer arithmetic wraps mod ENTRIES. Count distinguishes full from empty.

Optional Feature:
- LHR_QUEUE_BYPASS_EN
  - Defined: a lookup in the same cycle as an accepted allocation with AllocIndexD == IndexNextF returns AllocLHRD as a hit, because the new entry is the youngest.
  - Undefined: the lookup sees only pre-edge queue contents, giving a one-cycle bypass gap that is architecturally safe but loses accuracy.

Decomposition:
- Shared package: lhr_entry_t struct {valid, index[m], lhr[k]} and the age function (tag - head mod ENTRIES).
- Sub-module: lhr_youngest_match, a combinational age-ordered priority match over ENTRIES producing hit and selected LHR.

Test Plan:
- Reset, then IndexNextF=5 -> LookupHitF=0, EmptyD=1.
- Allocate idx5 LHR=0x155, then idx5 LHR=0x2AA; lookup 5 -> hit, LHR=0x2AA (youngest), AllocTagD sequence 0,1.
- Allocate 8 entries, then a 9th -> FullD=1 and the 9th has AllocOkD=0. CommitW once, then allocate -> accepted with tag 0 (wrap).
- Allocate tags 0..4; RepairE tag=1, RepairLHRE=0x001 -> count=2, tail=2, tags 2..4 invalid; lookups of their indices miss; lookup of tag 1's index -> 0x001.
- Same cycle AllocD with RepairE -> AllocOkD=0 and the entry is not written; same cycle AllocD with CommitW at count=3 -> count stays 3.
- StallF held 3 cycles while the queue changes -> outputs are frozen. With LHR_QUEUE_BYPASS_EN, same-cycle alloc/lookup of idx 9 -> hit next cycle; without it -> miss.

Source files
------------

// File: rtl/lhr_spec_queue_pkg.sv
// Shared types and helpers for the speculative local-history queue.
//   lhr_entry_t : one queue slot {valid, BHT index, speculative LHR}
//   age()       : distance of a slot from the head (0 = oldest)
package lhr_spec_queue_pkg;

  localparam int LHR_M   = 6;                 // BHT index width
  localparam int LHR_K   = 10;                // LHR width
  localparam int ENTRIES = 8;                 // queue depth, power of two
  localparam int TAGW    = $clog2(ENTRIES);   // slot tag width

  typedef logic [TAGW-1:0] tag_t;
  typedef logic [TAGW:0]   cnt_t;

  typedef struct packed {
    logic              valid;
    logic [LHR_M-1:0]  index;
    logic [LHR_K-1:0]  lhr;
  } lhr_entry_t;

  // Age relative to head; wraps naturally in TAGW bits because ENTRIES is a power of two.
  function automatic tag_t age(input tag_t tag, input tag_t head);
    return tag - head;
  endfunction

endpackage

// File: rtl/lhr_spec_queue_match.sv
// lhr_youngest_match: combinational age-ordered priority match.
//   entries : queue contents
//   head    : oldest slot; ages are measured from here
//   index   : BHT index being looked up
//   hit     : some valid entry holds this index
//   lhr     : LHR of the youngest such entry, 0 on miss
module lhr_youngest_match
  import lhr_spec_queue_pkg::*;
(
  input  lhr_entry_t        entries [ENTRIES],
  input  tag_t              head,
  input  logic [LHR_M-1:0]  index,
  output logic              hit,
  output logic [LHR_K-1:0]  lhr
);

  tag_t slot;
  logic match;

  // Walk from oldest to youngest so the last match seen (the youngest) wins.
  always_comb begin
    hit   = 1'b0;
    lhr   = '0;
    slot  = '0;
    match = 1'b0;
    for (int a = 0; a < ENTRIES; a++) begin
      slot  = head + tag_t'(a);
      match = entries[slot].valid && (entries[slot].index == index);
      hit   = hit | match;
      lhr   = match ? entries[slot].lhr : lhr;
    end
  end

endmodule

// File: rtl/lhr_spec_queue.sv
// lhr_spec_queue: ordered speculative local-history queue (small CAM).
//   F lookup : IndexNextF -> LookupHitF / LookupLHRF (registered, held on StallF)
//   D alloc  : AllocD/AllocIndexD/AllocLHRD -> AllocOkD, AllocTagD (comb)
//   E repair : RepairE/RepairTagE/RepairLHRE squash younger entries, fix LHR
//   W commit : CommitW pops the oldest entry
//   Status   : FullD, EmptyD
// Optional macro LHR_QUEUE_BYPASS_EN: a lookup that coincides with an accepted
// allocation of the same index returns the allocating LHR as a hit.
module lhr_spec_queue
  import lhr_spec_queue_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              StallF,
  input  logic [LHR_M-1:0]  IndexNextF,
  output logic              LookupHitF,
  output logic [LHR_K-1:0]  LookupLHRF,
  input  logic              AllocD,
  input  logic [LHR_M-1:0]  AllocIndexD,
  input  logic [LHR_K-1:0]  AllocLHRD,
  output logic              AllocOkD,
  output tag_t              AllocTagD,
  input  logic              RepairE,
  input  tag_t              RepairTagE,
  input  logic [LHR_K-1:0]  RepairLHRE,
  input  logic              CommitW,
  output logic              FullD,
  output logic              EmptyD
);

  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_FULL = cnt_t'(ENTRIES);

  lhr_entry_t        entries [ENTRIES];
  tag_t              head;
  tag_t              tail;
  cnt_t              count;
  cnt_t              count_base;
  cnt_t              count_next;
  logic              commit_ok;
  logic              match_hit;
  logic [LHR_K-1:0]  match_lhr;
  logic              lookup_hit;
  logic [LHR_K-1:0]  lookup_lhr;

  assign FullD     = (count == CNT_FULL);
  assign EmptyD    = (count == '0);
  assign AllocOkD  = AllocD & ~FullD & ~RepairE;  // repair flushes the younger D branch
  assign AllocTagD = tail;
  assign commit_ok = CommitW & ~EmptyD;

  // Occupancy after this cycle; repair recomputes it from the tag, where age+1
  // in TAGW+1 bits yields ENTRIES when the tag spans the whole queue.
  always_comb begin
    if (RepairE) begin
      count_base = {1'b0, age(RepairTagE, head)} + CNT_ONE;
    end else if (AllocOkD) begin
      count_base = count + CNT_ONE;
    end else begin
      count_base = count;
    end
    count_next = commit_ok ? (count_base - CNT_ONE) : count_base;
  end

  // Queue state: allocation or repair at the tail side, commit at the head side.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (RepairE) begin
        entries[RepairTagE].lhr <= RepairLHRE;
        for (int i = 0; i < ENTRIES; i++) begin
          if (age(tag_t'(i), head) > age(RepairTagE, head)) begin
            entries[i].valid <= 1'b0;
          end
        end
        tail <= RepairTagE + tag_t'(1);
      end else if (AllocOkD) begin
        entries[tail] <= '{valid: 1'b1, index: AllocIndexD, lhr: AllocLHRD};
        tail          <= tail + tag_t'(1);
      end
      // Placed last so a commit of the just-repaired sole entry clears it.
      if (commit_ok) begin
        entries[head].valid <= 1'b0;
        head                <= head + tag_t'(1);
      end
      count <= count_next;
    end
  end

  lhr_youngest_match u_match (
    .entries (entries),
    .head    (head),
    .index   (IndexNextF),
    .hit     (match_hit),
    .lhr     (match_lhr)
  );

`ifdef LHR_QUEUE_BYPASS_EN
  // Forward the allocating entry: it is younger than anything already queued.
  always_comb begin
    if (AllocOkD && (AllocIndexD == IndexNextF)) begin
      lookup_hit = 1'b1;
      lookup_lhr = AllocLHRD;
    end else begin
      lookup_hit = match_hit;
      lookup_lhr = match_lhr;
    end
  end
`else
  assign lookup_hit = match_hit;
  assign lookup_lhr = match_lhr;
`endif

  // F-stage result register, frozen while fetch is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      LookupHitF <= 1'b0;
      LookupLHRF <= '0;
    end else if (!StallF) begin
      LookupHitF <= lookup_hit;
      LookupLHRF <= lookup_lhr;
    end
  end

endmodule

// File: tb/tb_lhr_spec_queue.sv
// Directed self-checking bench for lhr_spec_queue.
module tb_lhr_spec_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       StallF;
  logic [5:0] IndexNextF;
  logic       LookupHitF;
  logic [9:0] LookupLHRF;
  logic       AllocD;
  logic [5:0] AllocIndexD;
  logic [9:0] AllocLHRD;
  logic       AllocOkD;
  logic [2:0] AllocTagD;
  logic       RepairE;
  logic [2:0] RepairTagE;
  logic [9:0] RepairLHRE;
  logic       CommitW;
  logic       FullD;
  logic       EmptyD;

  int checks = 0;
  int errors = 0;

  lhr_spec_queue dut (
    .clk(clk), .reset(reset), .StallF(StallF), .IndexNextF(IndexNextF),
    .LookupHitF(LookupHitF), .LookupLHRF(LookupLHRF),
    .AllocD(AllocD), .AllocIndexD(AllocIndexD), .AllocLHRD(AllocLHRD),
    .AllocOkD(AllocOkD), .AllocTagD(AllocTagD),
    .RepairE(RepairE), .RepairTagE(RepairTagE), .RepairLHRE(RepairLHRE),
    .CommitW(CommitW), .FullD(FullD), .EmptyD(EmptyD)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; StallF = 1'b0; AllocD = 1'b0; RepairE = 1'b0; CommitW = 1'b0;
    AllocIndexD = 6'd0; AllocLHRD = 10'd0; RepairTagE = 3'd0; RepairLHRE = 10'd0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic alloc(input logic [5:0] idx, input logic [9:0] l);
    AllocD = 1'b1; AllocIndexD = idx; AllocLHRD = l;
    tick();
    AllocD = 1'b0;
  endtask

  task automatic lookup(input logic [5:0] idx);
    IndexNextF = idx;
    tick();
  endtask

  task automatic test_reset();
    IndexNextF = 6'd5;
    do_reset();
    tick();
    checks++; if (LookupHitF !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", LookupHitF); end
    checks++; if (LookupLHRF !== 10'h000) begin errors++; $display("FAIL reset_lhr got %h exp 000", LookupLHRF); end
    checks++; if (EmptyD !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", EmptyD); end
    checks++; if (FullD !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", FullD); end
    checks++; if (AllocTagD !== 3'd0) begin errors++; $display("FAIL reset_tag got %0d exp 0", AllocTagD); end
  endtask

  task automatic test_youngest();
    do_reset();
    AllocD = 1'b1; AllocIndexD = 6'd5; AllocLHRD = 10'h155; #1;
    checks++; if (AllocOkD !== 1'b1) begin errors++; $display("FAIL young_ok0 got %b exp 1", AllocOkD); end
    checks++; if (AllocTagD !== 3'd0) begin errors++; $display("FAIL young_tag0 got %0d exp 0", AllocTagD); end
    tick();
    AllocLHRD = 10'h2AA; #1;
    checks++; if (AllocTagD !== 3'd1) begin errors++; $display("FAIL young_tag1 got %0d exp 1", AllocTagD); end
    tick();
    AllocD = 1'b0;
    lookup(6'd5);
    checks++; if (LookupHitF !== 1'b1) begin errors++; $display("FAIL young_hit got %b exp 1", LookupHitF); end
    checks++; if (LookupLHRF !== 10'h2AA) begin errors++; $display("FAIL young_lhr got %h exp 2aa", LookupLHRF); end
    lookup(6'd6);
    checks++; if (LookupHitF !== 1'b0 || LookupLHRF !== 10'h000) begin errors++; $display("FAIL young_miss got %b/%h exp 0/000", LookupHitF, LookupLHRF); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      AllocD = 1'b1; AllocIndexD = 6'(10 + i); AllocLHRD = 10'(i); #1;
      checks++; if (AllocTagD !== 3'(i) || AllocOkD !== 1'b1) begin errors++; $display("FAIL full_fill%0d got tag %0d ok %b", i, AllocTagD, AllocOkD); end
      tick();
    end
    AllocIndexD = 6'd20; AllocLHRD = 10'h0EE; #1;
    checks++; if (FullD !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", FullD); end
    checks++; if (AllocOkD !== 1'b0) begin errors++; $display("FAIL full_drop got %b exp 0", AllocOkD); end
    tick();
    CommitW = 1'b1; #1;
    checks++; if (AllocOkD !== 1'b0) begin errors++; $display("FAIL full_commit_drop got %b exp 0", AllocOkD); end
    tick();
    CommitW = 1'b0; AllocD = 1'b0;
    checks++; if (dut.count !== 4'd7 || FullD !== 1'b0) begin errors++; $display("FAIL full_after_commit count %0d exp 7", dut.count); end
    AllocD = 1'b1; AllocIndexD = 6'd30; AllocLHRD = 10'h3FF; #1;
    checks++; if (AllocOkD !== 1'b1 || AllocTagD !== 3'd0) begin errors++; $display("FAIL full_wrap got ok %b tag %0d exp 1/0", AllocOkD, AllocTagD); end
    tick();
    AllocD = 1'b0;
    checks++; if (FullD !== 1'b1) begin errors++; $display("FAIL full_refill got %b exp 1", FullD); end
    lookup(6'd30);
    checks++; if (LookupHitF !== 1'b1 || LookupLHRF !== 10'h3FF) begin errors++; $display("FAIL full_lk30 got %b/%h exp 1/3ff", LookupHitF, LookupLHRF); end
    lookup(6'd10);
    checks++; if (LookupHitF !== 1'b0) begin errors++; $display("FAIL full_lk10 got %b exp 0", LookupHitF); end
    lookup(6'd11);
    checks++; if (LookupHitF !== 1'b1 || LookupLHRF !== 10'h001) begin errors++; $display("FAIL full_lk11 got %b/%h exp 1/001", LookupHitF, LookupLHRF); end
  endtask

  task automatic test_repair();
    do_reset();
    for (int i = 0; i < 5; i++) alloc(6'(20 + i), 10'(10'h100 + i));
    RepairE = 1'b1; RepairTagE = 3'd1; RepairLHRE = 10'h001;
    tick();
    RepairE = 1'b0;
    checks++; if (dut.count !== 4'd2) begin errors++; $display("FAIL rep_count got %0d exp 2", dut.count); end
    checks++; if (AllocTagD !== 3'd2) begin errors++; $display("FAIL rep_tail got %0d exp 2", AllocTagD); end
    for (int i = 2; i < 5; i++) begin
      lookup(6'(20 + i));
      checks++; if (LookupHitF !== 1'b0) begin errors++; $display("FAIL rep_squash%0d got %b exp 0", i, LookupHitF); end
    end
    lookup(6'd21);
    checks++; if (LookupHitF !== 1'b1 || LookupLHRF !== 10'h001) begin errors++; $display("FAIL rep_fixed got %b/%h exp 1/001", LookupHitF, LookupLHRF); end
    lookup(6'd20);
    checks++; if (LookupLHRF !== 10'h100) begin errors++; $display("FAIL rep_older got %h exp 100", LookupLHRF); end
    CommitW = 1'b1; tick();
    RepairE = 1'b1; RepairTagE = 3'd1; RepairLHRE = 10'h002;
    tick();
    RepairE = 1'b0; CommitW = 1'b0;
    checks++; if (EmptyD !== 1'b1 || dut.count !== 4'd0) begin errors++; $display("FAIL rep_commit_only got empty %b count %0d exp 1/0", EmptyD, dut.count); end
    lookup(6'd21);
    checks++; if (LookupHitF !== 1'b0) begin errors++; $display("FAIL rep_commit_lk got %b exp 0", LookupHitF); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc(6'd40, 10'h040);
    AllocD = 1'b1; AllocIndexD = 6'd41; AllocLHRD = 10'h041;
    RepairE = 1'b1; RepairTagE = 3'd0; RepairLHRE = 10'h0AB; #1;
    checks++; if (AllocOkD !== 1'b0) begin errors++; $display("FAIL b2b_rep_drop got %b exp 0", AllocOkD); end
    tick();
    AllocD = 1'b0; RepairE = 1'b0;
    checks++; if (dut.count !== 4'd1 || AllocTagD !== 3'd1) begin errors++; $display("FAIL b2b_rep_state count %0d tag %0d exp 1/1", dut.count, AllocTagD); end
    lookup(6'd41);
    checks++; if (LookupHitF !== 1'b0) begin errors++; $display("FAIL b2b_rep_nowrite got %b exp 0", LookupHitF); end
    lookup(6'd40);
    checks++; if (LookupLHRF !== 10'h0AB) begin errors++; $display("FAIL b2b_rep_lhr got %h exp 0ab", LookupLHRF); end
    alloc(6'd42, 10'h042);
    alloc(6'd43, 10'h043);
    AllocD = 1'b1; AllocIndexD = 6'd44; AllocLHRD = 10'h044; CommitW = 1'b1; #1;
    checks++; if (AllocOkD !== 1'b1 || AllocTagD !== 3'd3) begin errors++; $display("FAIL b2b_ac_ok got %b tag %0d exp 1/3", AllocOkD, AllocTagD); end
    tick();
    AllocD = 1'b0; CommitW = 1'b0;
    checks++; if (dut.count !== 4'd3 || AllocTagD !== 3'd4) begin errors++; $display("FAIL b2b_ac_count count %0d tag %0d exp 3/4", dut.count, AllocTagD); end
    lookup(6'd40);
    checks++; if (LookupHitF !== 1'b0) begin errors++; $display("FAIL b2b_ac_popped got %b exp 0", LookupHitF); end
    lookup(6'd44);
    checks++; if (LookupHitF !== 1'b1 || LookupLHRF !== 10'h044) begin errors++; $display("FAIL b2b_ac_new got %b/%h exp 1/044", LookupHitF, LookupLHRF); end
  endtask

  task automatic test_stall();
    do_reset();
    alloc(6'd50, 10'h050);
    lookup(6'd50);
    checks++; if (LookupHitF !== 1'b1 || LookupLHRF !== 10'h050) begin errors++; $display("FAIL stall_pre got %b/%h exp 1/050", LookupHitF, LookupLHRF); end
    StallF = 1'b1;
    for (int c = 0; c < 3; c++) begin
      RepairE = (c == 0); RepairTagE = 3'd0; RepairLHRE = 10'h3C3;
      CommitW = (c == 1);
      AllocD = (c == 2); AllocIndexD = 6'd51; AllocLHRD = 10'h051;
      tick();
      checks++; if (LookupHitF !== 1'b1 || LookupLHRF !== 10'h050) begin errors++; $display("FAIL stall_hold%0d got %b/%h exp 1/050", c, LookupHitF, LookupLHRF); end
    end
    RepairE = 1'b0; CommitW = 1'b0; AllocD = 1'b0; StallF = 1'b0;
    lookup(6'd50);
    checks++; if (LookupHitF !== 1'b0 || LookupLHRF !== 10'h000) begin errors++; $display("FAIL stall_release got %b/%h exp 0/000", LookupHitF, LookupLHRF); end
    lookup(6'd51);
    checks++; if (LookupHitF !== 1'b1 || LookupLHRF !== 10'h051) begin errors++; $display("FAIL stall_new got %b/%h exp 1/051", LookupHitF, LookupLHRF); end
  endtask

  task automatic test_bypass();
    logic       exp_hit;
    logic [9:0] exp_lhr;
`ifdef LHR_QUEUE_BYPASS_EN
    exp_hit = 1'b1; exp_lhr = 10'h123;
`else
    exp_hit = 1'b0; exp_lhr = 10'h000;
`endif
    do_reset();
    IndexNextF = 6'd9;
    alloc(6'd9, 10'h123);
    checks++; if (LookupHitF !== exp_hit || LookupLHRF !== exp_lhr) begin errors++; $display("FAIL bypass_same got %b/%h exp %b/%h", LookupHitF, LookupLHRF, exp_hit, exp_lhr); end
    tick();
    checks++; if (LookupHitF !== 1'b1 || LookupLHRF !== 10'h123) begin errors++; $display("FAIL bypass_next got %b/%h exp 1/123", LookupHitF, LookupLHRF); end
  endtask

  initial begin
    test_reset();
    test_youngest();
    test_full();
    test_repair();
    test_back_to_back();
    test_stall();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
